// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw pins in, debounced level, press/release pulses and the
// shared tick out. The slave modport is the debouncer; master is the pin driver/consumer.
interface btn_debounce_if #(
  parameter int N_BTN = 7
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             tick;

  modport master (output btn_raw, input btn_level, input btn_press, input btn_release, input tick);
  modport slave  (input btn_raw, output btn_level, output btn_press, output btn_release, output tick);
endinterface

// File: rtl/btn_debounce.sv
// Button synchroniser + tick-based debouncer with press/release pulses.
// Define BTN_DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_debounce #(
  parameter int N_BTN              = 7,
  parameter int TICK_DIV           = 25000,
  parameter int DEBOUNCE_TICKS     = 16,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input logic          clk,
  input logic          rst_n,
  btn_debounce_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);
  // An illegal configuration leaves the prescaler silent, so nothing ever debounces.
  localparam bit PARAMS_OK = (TICK_DIV >= 2) && (DEBOUNCE_TICKS >= 1) &&
                             (REPEAT_DELAY_TICKS >= 1) && (REPEAT_RATE_TICKS >= 1);

  logic [N_BTN-1:0] sync1_reg, sync2_reg;
  logic [N_BTN-1:0] level_reg, press_reg, release_reg;
  logic [N_BTN-1:0] level_next, press_next, release_next;
  logic [N_BTN-1:0] flip;
  logic [PW-1:0]    presc_reg;
  logic             tick_reg;
  logic [CW-1:0]    cnt_reg  [N_BTN];
  logic [CW-1:0]    cnt_next [N_BTN];
  logic [N_BTN-1:0] rpt_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic differ;
      assign differ = sync2_reg[gi] ^ level_reg[gi];
      assign flip[gi] = differ && tick_reg && (cnt_reg[gi] == CNT_LAST);
      // Any cycle where input agrees with the level throws away partial progress.
      assign cnt_next[gi] = (!differ || flip[gi]) ? '0 :
                            (tick_reg ? cnt_reg[gi] + CW'(1) : cnt_reg[gi]);
      assign level_next[gi]   = level_reg[gi] ^ flip[gi];
      assign press_next[gi]   = (flip[gi] && !level_reg[gi]) || rpt_pulse[gi];
      assign release_next[gi] = flip[gi] && level_reg[gi];
    end
  endgenerate

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                    : REPEAT_RATE_TICKS;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_TICKS - 1);

  logic [RW-1:0]    rpt_reg  [N_BTN];
  logic [RW-1:0]    rpt_next [N_BTN];
  logic [N_BTN-1:0] phase_reg, phase_next;

  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_rpt
      logic active;
      // Counting only while held and not in the edge where the level itself flips.
      assign active = level_reg[gi] && !flip[gi];
      assign rpt_pulse[gi] = active && tick_reg &&
                             (rpt_reg[gi] == (phase_reg[gi] ? RATE_LAST : DELAY_LAST));
      assign rpt_next[gi] = (!active || rpt_pulse[gi]) ? '0 :
                            (tick_reg ? rpt_reg[gi] + RW'(1) : rpt_reg[gi]);
      assign phase_next[gi] = active && (phase_reg[gi] || rpt_pulse[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
      for (int i = 0; i < N_BTN; i++) rpt_reg[i] <= '0;
    end else begin
      phase_reg <= phase_next;
      rpt_reg   <= rpt_next;
    end
  end
`else
  assign rpt_pulse = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      level_reg   <= '0;
      press_reg   <= '0;
      release_reg <= '0;
      presc_reg   <= '0;
      tick_reg    <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt_reg[i] <= '0;
    end else begin
      sync1_reg   <= bus.btn_raw;
      sync2_reg   <= sync1_reg;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      presc_reg   <= (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
      tick_reg    <= PARAMS_OK && (presc_reg == PRESC_LAST);
      cnt_reg     <= cnt_next;
    end
  end

  assign bus.btn_level   = level_reg;
  assign bus.btn_press   = press_reg;
  assign bus.btn_release = release_reg;
  assign bus.tick        = tick_reg;

endmodule
